wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/load_align.sv | 33 +++
 rtl/wb_stage.sv | 87 ++++++++
 tb/tb_wb_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: data/register widths, load-size encodings and the MEM/WB register layout.
package pipe_pkg;

    localparam int XLEN      = 32;
    localparam int REGADDR_W = 5;

    typedef enum logic [1:0] {
        LS_WORD = 2'd0,
        LS_HALF = 2'd1,
        LS_BYTE = 2'd2,
        LS_RSVD = 2'd3
    } loadsize_t;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memtoreg;
        logic [REGADDR_W-1:0] rd;
        logic [XLEN-1:0]      aluresult;
        logic [XLEN-1:0]      readdata;
        loadsize_t            loadsize;
        logic                 loadsigned;
    } memwb_t;

    // Byte loads can never be misaligned; the reserved size behaves like a word.
    function automatic logic is_misaligned(input loadsize_t size, input logic [1:0] offset);
        case (size)
            LS_HALF: is_misaligned = offset[0];
            LS_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = (offset != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment: picks the addressed byte/half out of a memory word and extends it.
module load_align
    import pipe_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  loadsize_t       size,
    input  logic            load_signed,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 is the most significant lane; a misaligned half still only looks at offset[1].
    always_comb begin
        byte_sel = 8'd0;
        half_sel = offset[1] ? word[15:0] : word[31:16];
        data     = word;
        case (offset)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        case (size)
            LS_BYTE: data = {{24{load_signed & byte_sel[7]}}, byte_sel};
            LS_HALF: data = {{16{load_signed & half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load alignment, retire counter and sticky misalign flag.
// Defining WB_BYPASS_EN adds a WB->ID forwarding mux on the register-file read operands.
module wb_stage
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_regwrite,
    input  logic                 mem_memtoreg,
    input  logic [REGADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]      mem_aluresult,
    input  logic [XLEN-1:0]      mem_readdata,
    input  logic [1:0]           mem_loadsize,
    input  logic                 mem_loadsigned,
    input  logic                 stall,
    input  logic                 flush,
`ifdef WB_BYPASS_EN
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic [XLEN-1:0]      rf_A,
    input  logic [XLEN-1:0]      rf_B,
    output logic [XLEN-1:0]      A_fwd,
    output logic [XLEN-1:0]      B_fwd,
`endif
    output logic                 regwrite,
    output logic [REGADDR_W-1:0] rd,
    output logic [XLEN-1:0]      writedata,
    output logic                 wb_valid,
    output logic [XLEN-1:0]      retire_count,
    output logic                 misalign_err
);

    memwb_t          r;
    memwb_t          capture;
    logic [XLEN-1:0] load_data;

    always_comb begin
        capture            = '0;
        capture.valid      = mem_valid;
        capture.regwrite   = mem_regwrite;
        capture.memtoreg   = mem_memtoreg;
        capture.rd         = mem_rd;
        capture.aluresult  = mem_aluresult;
        capture.readdata   = mem_readdata;
        capture.loadsize   = loadsize_t'(mem_loadsize);
        capture.loadsigned = mem_loadsigned;
    end

    // The instruction sitting in WB retires whenever the stage is not stalled; flush only kills the incoming slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r            <= '0;
            retire_count <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (r.valid && !stall)
                retire_count <= retire_count + 32'd1;
            if (flush) begin
                r.valid <= 1'b0;
            end else if (!stall) begin
                r <= capture;
                if (mem_valid && mem_memtoreg && is_misaligned(capture.loadsize, mem_aluresult[1:0]))
                    misalign_err <= 1'b1;
            end
        end
    end

    load_align u_align (
        .word        (r.readdata),
        .offset      (r.aluresult[1:0]),
        .size        (r.loadsize),
        .load_signed (r.loadsigned),
        .data        (load_data)
    );

    assign wb_valid  = r.valid;
    assign rd        = r.rd;
    assign regwrite  = r.valid & r.regwrite & (r.rd != '0);
    assign writedata = r.memtoreg ? load_data : r.aluresult;

`ifdef WB_BYPASS_EN
    assign A_fwd = (regwrite && id_rs == r.rd) ? writedata : rf_A;
    assign B_fwd = (regwrite && id_rt == r.rd) ? writedata : rf_B;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus random traffic against a behavioural model.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid, mem_regwrite, mem_memtoreg, mem_loadsigned;
    logic [4:0]  mem_rd;
    logic [31:0] mem_aluresult, mem_readdata;
    logic [1:0]  mem_loadsize;
    logic        stall, flush;
    logic        regwrite, wb_valid, misalign_err;
    logic [4:0]  rd;
    logic [31:0] writedata, retire_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  id_rs, id_rt;
    logic [31:0] rf_A, rf_B, A_fwd, B_fwd;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model of the architectural state seen at the WB outputs.
    logic        mValid, mRegwrite, mMemtoreg, mSigned, mErr, mKnown;
    logic [4:0]  mRd;
    logic [31:0] mAlu, mRead, mCount;
    logic [1:0]  mSize;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_regwrite   (mem_regwrite),
        .mem_memtoreg   (mem_memtoreg),
        .mem_rd         (mem_rd),
        .mem_aluresult  (mem_aluresult),
        .mem_readdata   (mem_readdata),
        .mem_loadsize   (mem_loadsize),
        .mem_loadsigned (mem_loadsigned),
        .stall          (stall),
        .flush          (flush),
`ifdef WB_BYPASS_EN
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .rf_A           (rf_A),
        .rf_B           (rf_B),
        .A_fwd          (A_fwd),
        .B_fwd          (B_fwd),
`endif
        .regwrite       (regwrite),
        .rd             (rd),
        .writedata      (writedata),
        .wb_valid       (wb_valid),
        .retire_count   (retire_count),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Loaded value straight from the big-endian lane rules, using shifts on the raw word.
    function automatic logic [31:0] expLoad(input logic [31:0] w, input logic [31:0] alu,
                                            input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        if (size == 2'd2) begin
            v = (w >> (8 * (3 - alu[1:0]))) & 32'hFF;
            if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * (1 - alu[1]))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic expMisalign(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd2) return 1'b0;
        if (size == 2'd1) return off[0];
        return off != 2'd0;
    endfunction

    task automatic compareAll(input string tag);
        logic [31:0] expWd;
        expWd = mMemtoreg ? expLoad(mRead, mAlu, mSize, mSigned) : mAlu;
        checkOutput({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, mValid});
        checkOutput({tag, ".regwrite"}, {31'd0, regwrite},
                    {31'd0, mValid && mRegwrite && mRd != 5'd0});
        checkOutput({tag, ".retire"}, retire_count, mCount);
        checkOutput({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, mErr});
        if (mKnown) begin
            checkOutput({tag, ".rd"}, {27'd0, rd}, {27'd0, mRd});
            checkOutput({tag, ".wdata"}, writedata, expWd);
        end
`ifdef WB_BYPASS_EN
        checkOutput({tag, ".A_fwd"}, A_fwd,
                    (mValid && mRegwrite && mRd != 5'd0 && id_rs == mRd) ? expWd : rf_A);
        checkOutput({tag, ".B_fwd"}, B_fwd,
                    (mValid && mRegwrite && mRd != 5'd0 && id_rt == mRd) ? expWd : rf_B);
`endif
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare #1 after the edge.
    task automatic applyStimulus(input string tag, input logic v, input logic rw, input logic mtr,
                                 input logic [4:0] d, input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic [1:0] size, input logic sgn,
                                 input logic st, input logic fl, input logic r);
        mem_valid = v; mem_regwrite = rw; mem_memtoreg = mtr; mem_rd = d;
        mem_aluresult = alu; mem_readdata = rdata; mem_loadsize = size; mem_loadsigned = sgn;
        stall = st; flush = fl; rst = r;
        @(posedge clk);
        if (r) begin
            {mValid, mRegwrite, mMemtoreg, mSigned, mErr} = '0;
            mRd = '0; mAlu = '0; mRead = '0; mSize = '0; mCount = '0; mKnown = 1'b1;
        end else begin
            if (mValid && !st) mCount = mCount + 32'd1;
            if (fl) begin
                mValid = 1'b0;
                mKnown = 1'b0;
            end else if (!st) begin
                mValid = v; mRegwrite = rw; mMemtoreg = mtr; mRd = d;
                mAlu = alu; mRead = rdata; mSize = size; mSigned = sgn; mKnown = 1'b1;
                if (v && mtr && expMisalign(size, alu[1:0])) mErr = 1'b1;
            end
        end
        #1;
        compareAll(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        {mValid, mRegwrite, mMemtoreg, mSigned, mErr, mKnown} = '0;
        mRd = '0; mAlu = '0; mRead = '0; mSize = '0; mCount = '0;
`ifdef WB_BYPASS_EN
        id_rs = 5'd0; id_rt = 5'd0; rf_A = 32'd0; rf_B = 32'd0;
`endif
        applyStimulus("reset", 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("reset.wdata_zero", writedata, 32'd0);
        idle("post_reset");
        checkOutput("post_reset.wdata_zero", writedata, 32'd0);

        // ALU result through to regfile, counted on the following edge.
        applyStimulus("alu", 1'b1, 1'b1, 1'b0, 5'd2, 32'h2393_8222, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("alu.wdata_const", writedata, 32'h2393_8222);
        idle("alu_retire");
        checkOutput("alu.retire_const", retire_count, 32'd1);

        applyStimulus("lb_s_off3", 1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_0103, 32'h1112_1951, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lb_s_off3.const", writedata, 32'h0000_0051);
        applyStimulus("lbu_off0", 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0100, 32'h1112_1951, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lbu_off0.const", writedata, 32'h0000_0011);
        applyStimulus("lh_s_off0", 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_0200, 32'h9396_ABCD, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lh_s_off0.const", writedata, 32'hFFFF_9396);

        applyStimulus("rd0", 1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rd0.regwrite_const", {31'd0, regwrite}, 32'd0);
        idle("rd0_retire");

        // Hold an instruction in WB for three stalled edges, then let it retire.
        applyStimulus("pre_stall", 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_9999, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", 1'b1, 1'b1, 1'b0, 5'd10, 32'h5555_0000 + i, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("stall_release");
        applyStimulus("pre_sf", 1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0011, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("stall_flush", 1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0012, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("stall_flush.valid_const", {31'd0, wb_valid}, 32'd0);

        applyStimulus("lh_off1", 1'b1, 1'b1, 1'b1, 5'd13, 32'h0000_0001, 32'hAABB_CCDD, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lh_off1.err_const", {31'd0, misalign_err}, 32'd1);
        for (int i = 0; i < 10; i++) idle("err_hold");
        applyStimulus("err_reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef WB_BYPASS_EN
        applyStimulus("fwd", 1'b1, 1'b1, 1'b0, 5'd3, 32'h1939_6328, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_rs = 5'd3; id_rt = 5'd4; rf_A = 32'd0; rf_B = 32'hCAFE_F00D;
        #1;
        checkOutput("fwd.A_const", A_fwd, 32'h1939_6328);
        checkOutput("fwd.B_const", B_fwd, 32'hCAFE_F00D);
`endif

        // Counter wrap: preload the counter just below the edge where a valid instruction retires.
        applyStimulus("pre_wrap", 1'b1, 1'b1, 1'b0, 5'd1, 32'h0000_0001, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        force dut.retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count;
        mCount = 32'hFFFF_FFFF;
        idle("wrap");
        checkOutput("wrap.const", retire_count, 32'd0);

        for (int i = 0; i < 400; i++) begin
`ifdef WB_BYPASS_EN
            id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
            rf_A = $urandom; rf_B = $urandom;
`endif
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 7)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                          1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
